alu_share_ctrl: RTL and testbench

- Sequences and shares one RV32I Alu instance between two requesters over valid/ready handshakes.
- Requester 0 is the core execute stage; requester 1 is the address-generation/auxiliary path.
- Arbitrates round-robin (or fixed priority by parameter), registers operands, runs the Alu for one cycle, and holds the registered result until the owning requester accepts it.
- Sits between the execute-stage control and the Alu datapath.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu.sv | 39 +++
 rtl/alu_share_ctrl.sv | 118 +++++++++++
 tb/tb_alu_share_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU op encodings, controller state encoding and requester count
// for the shared-ALU controller.
package alu_pkg;

    localparam int NUM_REQ = 2;

    // Op encoding is {instr[30], funct3}
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu.sv
// RV32I integer ALU, purely combinational. Unknown op codes fall back to ADD.
module alu
    import alu_pkg::*;
#(
    parameter int XLEN = 32
)
(
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result
);

    logic [4:0] shamt_s;
    logic       slt_s;
    logic       sltu_s;

    assign shamt_s = b[4:0];
    assign slt_s   = ($signed(a) < $signed(b));
    assign sltu_s  = (a < b);

    // Operation select
    always_comb begin
        case (op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_SLL:  result = a << shamt_s;
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, slt_s};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, sltu_s};
            ALU_XOR:  result = a ^ b;
            ALU_SRL:  result = a >> shamt_s;
            ALU_SRA:  result = $signed(a) >>> shamt_s;
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            default:  result = a + b;
        endcase
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one ALU between the execute stage (port 0) and the address/aux path
// (port 1): arbitrate, register operands, execute one cycle, hold result.
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0,
    parameter int XLEN       = 32
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] req_ready,
    input  logic [3:0]         req_op0,
    input  logic [3:0]         req_op1,
    input  logic [XLEN-1:0]    req_a0,
    input  logic [XLEN-1:0]    req_a1,
    input  logic [XLEN-1:0]    req_b0,
    input  logic [XLEN-1:0]    req_b1,
    output logic [NUM_REQ-1:0] rsp_valid,
    input  logic [NUM_REQ-1:0] rsp_ready,
    output logic [XLEN-1:0]    rsp_result,
    output logic               busy
);

    state_e          state_r;
    logic            owner_r;
    logic            last_grant_r;
    logic [3:0]      op_r;
    logic [XLEN-1:0] a_r;
    logic [XLEN-1:0] b_r;
    logic [XLEN-1:0] result_r;
    logic [XLEN-1:0] alu_result_s;
    logic            grant_valid_s;
    logic            grant_idx_s;

    // Arbitration; grants only in IDLE and never while reset is applied
    always_comb begin
        grant_valid_s = 1'b0;
        grant_idx_s   = 1'b0;
        if ((state_r == IDLE) && !rst) begin
            if (req_valid == 2'b11) begin
                grant_valid_s = 1'b1;
                grant_idx_s   = FIXED_PRIO ? 1'b0 : ~last_grant_r;
            end else if (req_valid[0]) begin
                grant_valid_s = 1'b1;
                grant_idx_s   = 1'b0;
            end else if (req_valid[1]) begin
                grant_valid_s = 1'b1;
                grant_idx_s   = 1'b1;
            end else begin
                grant_valid_s = 1'b0;
                grant_idx_s   = 1'b0;
            end
        end else begin
            grant_valid_s = 1'b0;
            grant_idx_s   = 1'b0;
        end
    end

    assign req_ready  = grant_valid_s ? (grant_idx_s ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_result = result_r;

    // ALU sees only the registered operands, isolating it from requester inputs
    alu #(.XLEN(XLEN)) u_alu (
        .op     (op_r),
        .a      (a_r),
        .b      (b_r),
        .result (alu_result_s)
    );

    // Controller FSM with registered response and busy outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            owner_r      <= 1'b0;
            last_grant_r <= 1'b1;
            op_r         <= 4'b0000;
            a_r          <= '0;
            b_r          <= '0;
            result_r     <= '0;
            rsp_valid    <= 2'b00;
            busy         <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_valid_s) begin
                        op_r         <= grant_idx_s ? req_op1 : req_op0;
                        a_r          <= grant_idx_s ? req_a1 : req_a0;
                        b_r          <= grant_idx_s ? req_b1 : req_b0;
                        owner_r      <= grant_idx_s;
                        last_grant_r <= grant_idx_s;
                        busy         <= 1'b1;
                        state_r      <= EXEC;
                    end
                end
                EXEC: begin
                    result_r  <= alu_result_s;
                    rsp_valid <= owner_r ? 2'b10 : 2'b01;
                    state_r   <= RESP;
                end
                RESP: begin
                    if (rsp_ready[owner_r]) begin
                        rsp_valid <= 2'b00;
                        busy      <= 1'b0;
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 2'b00;
                    busy      <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed self-checking bench for alu_share_ctrl: round-robin and
// fixed-priority instances share one stimulus set.
module tb_alu_share_ctrl;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  rsp_ready;
    logic [3:0]  req_op0, req_op1;
    logic [31:0] req_a0, req_a1, req_b0, req_b1;

    logic [1:0]  rdy_rr, vld_rr, rdy_fp, vld_fp;
    logic [31:0] res_rr, res_fp;
    logic        busy_rr, busy_fp;

    logic        sel_fp = 1'b0;
    logic [1:0]  rdy_m, vld_m;
    logic [31:0] res_m;
    logic        busy_m;

    int tests_run    = 0;
    int tests_failed = 0;
    int bad_rdy      = 0;

    always #5 clk = ~clk;

    alu_share_ctrl #(.FIXED_PRIO(1'b0), .XLEN(32)) dut_rr (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy_rr),
        .req_op0(req_op0), .req_op1(req_op1), .req_a0(req_a0), .req_a1(req_a1),
        .req_b0(req_b0), .req_b1(req_b1), .rsp_valid(vld_rr), .rsp_ready(rsp_ready),
        .rsp_result(res_rr), .busy(busy_rr)
    );

    alu_share_ctrl #(.FIXED_PRIO(1'b1), .XLEN(32)) dut_fp (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy_fp),
        .req_op0(req_op0), .req_op1(req_op1), .req_a0(req_a0), .req_a1(req_a1),
        .req_b0(req_b0), .req_b1(req_b1), .rsp_valid(vld_fp), .rsp_ready(rsp_ready),
        .rsp_result(res_fp), .busy(busy_fp)
    );

    assign rdy_m  = sel_fp ? rdy_fp  : rdy_rr;
    assign vld_m  = sel_fp ? vld_fp  : vld_rr;
    assign res_m  = sel_fp ? res_fp  : res_rr;
    assign busy_m = sel_fp ? busy_fp : busy_rr;

    // req_ready must never grant both ports at once
    always @(negedge clk) begin
        #1;
        if (rdy_rr == 2'b11 || rdy_fp == 2'b11) bad_rdy++;
    end

    // Issue one op on a port and wait (bounded) for its response; lat = -1 on timeout
    task automatic run_op(input bit port, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit keep,
                          output logic [31:0] res, output logic [1:0] vld, output int lat);
        int n;
        res = 32'd0;
        vld = 2'b00;
        lat = -1;
        if (port == 1'b0) begin
            req_op0 = op; req_a0 = a; req_b0 = b;
        end else begin
            req_op1 = op; req_a1 = a; req_b1 = b;
        end
        req_valid[port] = 1'b1;
        #1;
        n = 0;
        while (!rdy_m[port] && n < 20) begin
            @(negedge clk); #1; n++;
        end
        if (rdy_m[port]) begin
            @(posedge clk);
            @(negedge clk);
            if (!keep) req_valid[port] = 1'b0;
            n = 1;
            while (vld_m == 2'b00 && n < 10) begin
                @(negedge clk); n++;
            end
            if (vld_m != 2'b00) begin
                lat = n; res = res_m; vld = vld_m;
            end
            @(negedge clk);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = 2'b00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        repeat (3) @(negedge clk);
        #1;
        tests_run++; if (vld_m !== 2'b00) begin tests_failed++; $display("FAIL reset_rsp_valid: got %b want 00", vld_m); end
        tests_run++; if (res_m !== 32'd0) begin tests_failed++; $display("FAIL reset_rsp_result: got %h want 0", res_m); end
        tests_run++; if (busy_m !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy_m); end
        tests_run++; if (rdy_m !== 2'b00) begin tests_failed++; $display("FAIL reset_req_ready: got %b want 00", rdy_m); end
        rst = 1'b0;
    endtask

    task automatic test_sub_latency();
        @(negedge clk);
        req_op0 = ALU_SUB; req_a0 = 32'd5; req_b0 = 32'd7;
        req_valid = 2'b01; rsp_ready = 2'b11;
        #1;
        tests_run++; if (rdy_m !== 2'b01) begin tests_failed++; $display("FAIL sub_req_ready: got %b want 01", rdy_m); end
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        tests_run++; if (busy_m !== 1'b1) begin tests_failed++; $display("FAIL sub_busy_t1: got %b want 1", busy_m); end
        tests_run++; if (vld_m !== 2'b00) begin tests_failed++; $display("FAIL sub_valid_t1: got %b want 00", vld_m); end
        @(negedge clk); #1;
        tests_run++; if (vld_m !== 2'b01) begin tests_failed++; $display("FAIL sub_valid_t2: got %b want 01", vld_m); end
        tests_run++; if (res_m !== 32'hFFFF_FFFE) begin tests_failed++; $display("FAIL sub_result: got %h want fffffffe", res_m); end
        tests_run++; if (busy_m !== 1'b1) begin tests_failed++; $display("FAIL sub_busy_t2: got %b want 1", busy_m); end
        @(negedge clk); #1;
        tests_run++; if (vld_m !== 2'b00) begin tests_failed++; $display("FAIL sub_valid_drop: got %b want 00", vld_m); end
        tests_run++; if (busy_m !== 1'b0) begin tests_failed++; $display("FAIL sub_busy_drop: got %b want 0", busy_m); end
    endtask

    task automatic test_shifts();
        logic [3:0]  ops  [4];
        logic [31:0] as   [4];
        logic [31:0] bs   [4];
        logic [31:0] exps [4];
        bit          ports[4];
        logic [31:0] res;
        logic [1:0]  vld;
        logic [1:0]  exp_vld;
        int          lat;
        ops[0] = ALU_SRA; as[0] = 32'h8000_0000; bs[0] = 32'd4;  exps[0] = 32'hF800_0000; ports[0] = 1'b1;
        ops[1] = ALU_SRL; as[1] = 32'h8000_0000; bs[1] = 32'd4;  exps[1] = 32'h0800_0000; ports[1] = 1'b1;
        ops[2] = ALU_SLL; as[2] = 32'd1;         bs[2] = 32'd33; exps[2] = 32'h0000_0002; ports[2] = 1'b1;
        ops[3] = ALU_SLT; as[3] = 32'hFFFF_FFFF; bs[3] = 32'd1;  exps[3] = 32'h0000_0001; ports[3] = 1'b0;
        rsp_ready = 2'b11;
        for (int i = 0; i < 4; i++) begin
            run_op(ports[i], ops[i], as[i], bs[i], 1'b0, res, vld, lat);
            exp_vld = ports[i] ? 2'b10 : 2'b01;
            tests_run++; if (res !== exps[i]) begin tests_failed++; $display("FAIL shift_result[%0d]: got %h want %h", i, res, exps[i]); end
            tests_run++; if (vld !== exp_vld) begin tests_failed++; $display("FAIL shift_valid[%0d]: got %b want %b", i, vld, exp_vld); end
            tests_run++; if (lat != 2) begin tests_failed++; $display("FAIL shift_latency[%0d]: got %0d want 2", i, lat); end
        end
    endtask

    task automatic test_tie_after_reset();
        logic [31:0] res;
        logic [1:0]  vld;
        int          lat;
        apply_reset();
        rsp_ready = 2'b11;
        req_op0 = ALU_ADD;  req_a0 = 32'd1; req_b0 = 32'd2;
        req_op1 = ALU_SLTU; req_a1 = 32'd1; req_b1 = 32'hFFFF_FFFF;
        req_valid = 2'b11;
        #1;
        tests_run++; if (rdy_m !== 2'b01) begin tests_failed++; $display("FAIL tie_first_grant: got %b want 01", rdy_m); end
        run_op(1'b0, ALU_ADD, 32'd1, 32'd2, 1'b0, res, vld, lat);
        tests_run++; if (res !== 32'd3) begin tests_failed++; $display("FAIL tie_add_result: got %h want 3", res); end
        tests_run++; if (vld !== 2'b01) begin tests_failed++; $display("FAIL tie_add_valid: got %b want 01", vld); end
        #1;
        tests_run++; if (rdy_m !== 2'b10) begin tests_failed++; $display("FAIL tie_second_grant: got %b want 10", rdy_m); end
        run_op(1'b1, ALU_SLTU, 32'd1, 32'hFFFF_FFFF, 1'b0, res, vld, lat);
        tests_run++; if (res !== 32'd1) begin tests_failed++; $display("FAIL tie_sltu_result: got %h want 1", res); end
        tests_run++; if (vld !== 2'b10) begin tests_failed++; $display("FAIL tie_sltu_valid: got %b want 10", vld); end
        req_op0 = ALU_ADD; req_a0 = 32'd4; req_b0 = 32'd5;
        req_valid = 2'b11;
        #1;
        tests_run++; if (rdy_m !== 2'b01) begin tests_failed++; $display("FAIL tie_rr_back_to_0: got %b want 01", rdy_m); end
        run_op(1'b0, ALU_ADD, 32'd4, 32'd5, 1'b0, res, vld, lat);
        req_valid = 2'b00;
        tests_run++; if (res !== 32'd9) begin tests_failed++; $display("FAIL tie_add2_result: got %h want 9", res); end
        tests_run++; if (bad_rdy != 0) begin tests_failed++; $display("FAIL ready_onehot: got %0d double grants want 0", bad_rdy); end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        rsp_ready = 2'b00;
        req_op0 = ALU_XOR; req_a0 = 32'h0000_F0F0; req_b0 = 32'h0000_0FF0;
        req_valid = 2'b01;
        #1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        req_a0 = 32'hFFFF_FFFF; req_b0 = 32'd0; req_op0 = ALU_OR;
        rsp_ready = 2'b10;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            tests_run++; if (vld_m !== 2'b01) begin tests_failed++; $display("FAIL bp_valid[%0d]: got %b want 01", i, vld_m); end
            tests_run++; if (res_m !== 32'h0000_FF00) begin tests_failed++; $display("FAIL bp_result[%0d]: got %h want 0000ff00", i, res_m); end
        end
        rsp_ready = 2'b11;
        @(negedge clk); #1;
        tests_run++; if (vld_m !== 2'b00) begin tests_failed++; $display("FAIL bp_release_valid: got %b want 00", vld_m); end
        tests_run++; if (busy_m !== 1'b0) begin tests_failed++; $display("FAIL bp_release_busy: got %b want 0", busy_m); end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] res;
        logic [1:0]  vld;
        int          lat;
        @(negedge clk);
        rsp_ready = 2'b11;
        req_op1 = ALU_AND; req_a1 = 32'hFF00_FF00; req_b1 = 32'h0F0F_0F0F;
        req_valid = 2'b10;
        #1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests_run++; if (vld_m !== 2'b00) begin tests_failed++; $display("FAIL rstmid_valid: got %b want 00", vld_m); end
        tests_run++; if (busy_m !== 1'b0) begin tests_failed++; $display("FAIL rstmid_busy: got %b want 0", busy_m); end
        tests_run++; if (res_m !== 32'd0) begin tests_failed++; $display("FAIL rstmid_result: got %h want 0", res_m); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            tests_run++; if (vld_m !== 2'b00) begin tests_failed++; $display("FAIL rstmid_no_rsp[%0d]: got %b want 00", i, vld_m); end
        end
        // Abort a port-0 op so only the reset value of last_grant can favour port 0
        req_op0 = ALU_ADD; req_a0 = 32'd10; req_b0 = 32'd20;
        req_valid = 2'b01;
        #1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req_valid = 2'b11;
        #1;
        tests_run++; if (rdy_m !== 2'b01) begin tests_failed++; $display("FAIL rstmid_tie_grant: got %b want 01", rdy_m); end
        run_op(1'b0, ALU_ADD, 32'd10, 32'd20, 1'b0, res, vld, lat);
        req_valid = 2'b00;
        tests_run++; if (res !== 32'd30) begin tests_failed++; $display("FAIL rstmid_after_result: got %h want 30", res); end
    endtask

    task automatic test_fixed_prio();
        logic [31:0] res;
        logic [1:0]  vld;
        int          lat;
        apply_reset();
        sel_fp = 1'b1;
        rsp_ready = 2'b11;
        req_op1 = ALU_SUB; req_a1 = 32'd9; req_b1 = 32'd3;
        req_op0 = 4'b1111; req_a0 = 32'd2; req_b0 = 32'd3;
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #1;
            tests_run++; if (rdy_m !== 2'b01) begin tests_failed++; $display("FAIL fp_grant[%0d]: got %b want 01", i, rdy_m); end
            run_op(1'b0, 4'b1111, 32'd2, 32'd3, 1'b1, res, vld, lat);
            tests_run++; if (res !== 32'd5) begin tests_failed++; $display("FAIL fp_unknown_op_result[%0d]: got %h want 5", i, res); end
            tests_run++; if (vld !== 2'b01) begin tests_failed++; $display("FAIL fp_valid[%0d]: got %b want 01", i, vld); end
        end
        req_valid = 2'b00;
        sel_fp = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        req_op0 = 4'b0000; req_op1 = 4'b0000;
        req_a0 = 32'd0; req_a1 = 32'd0; req_b0 = 32'd0; req_b1 = 32'd0;
        test_reset();
        test_sub_latency();
        test_shifts();
        test_tie_after_reset();
        test_backpressure();
        test_reset_mid_op();
        test_fixed_prio();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
